// File: rtl/wdata_mc_fifo_pkg.sv
// rtl/wdata_mc_fifo_pkg.sv - shared parameter defaults and pointer width rule
// Purpose: one place for the write-data FIFO defaults and the rule that
// pointers and counts carry one extra bit beyond the storage address.
// Ports: none (package).
package wdata_mc_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 1024;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_AFULL_TH   = 12;

  // Pointers and occupancy counts are ADDR_W+1 bits: the extra MSB tells
  // a full channel apart from an empty one, and the count reaches 2^ADDR_W.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/wdata_mc_fifo_if.sv
// rtl/wdata_mc_fifo_if.sv - request/status bundle of the multi-channel write-data FIFO
// Purpose: groups the write, read, flush and status signals of wdata_mc_fifo.
// Ports (master drives requests, slave drives status):
//   i_wr_en, i_wr_ch, i_data   write request, target channel, write beat
//   i_rd_en, i_rd_ch           pop request and channel shown on o_data
//   i_flush[NUM_CH]            per-channel synchronous flush
//   i_err_clr                  clears sticky error flags
//   o_data                     FWFT head of channel i_rd_ch
//   o_full/o_empty/o_afull     per-channel registered status
//   o_count                    per-channel occupancy, ADDR_W+1 bits each
//   o_err_ovf/o_err_udf        sticky overflow / underflow
interface wdata_mc_fifo_if
  import wdata_mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_CH     = DEF_NUM_CH
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = ptr_w(ADDR_W);

  logic                    i_wr_en;
  logic [CH_W-1:0]         i_wr_ch;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    i_rd_en;
  logic [CH_W-1:0]         i_rd_ch;
  logic [NUM_CH-1:0]       i_flush;
  logic                    i_err_clr;
  logic [DATA_WIDTH-1:0]   o_data;
  logic [NUM_CH-1:0]       o_full;
  logic [NUM_CH-1:0]       o_empty;
  logic [NUM_CH-1:0]       o_afull;
  logic [NUM_CH*PTR_W-1:0] o_count;
  logic                    o_err_ovf;
  logic                    o_err_udf;

  modport master (
    output i_wr_en, i_wr_ch, i_data, i_rd_en, i_rd_ch, i_flush, i_err_clr,
    input  o_data, o_full, o_empty, o_afull, o_count, o_err_ovf, o_err_udf
  );

  modport slave (
    input  i_wr_en, i_wr_ch, i_data, i_rd_en, i_rd_ch, i_flush, i_err_clr,
    output o_data, o_full, o_empty, o_afull, o_count, o_err_ovf, o_err_udf
  );

endinterface

// File: rtl/wdata_ch_fifo.sv
// rtl/wdata_ch_fifo.sv - single-channel first-word-fall-through write-data FIFO
// Purpose: storage, pointers, registered status and flush for one channel.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_wr_req, i_rd_req     decoded write / pop request for this channel
//   i_flush                drop all entries on the next edge
//   i_data                 write beat
//   o_head                 current head entry (combinational)
//   o_full/o_empty/o_afull registered status
//   o_count                registered occupancy
//   o_ovf_hit, o_udf_hit   this-cycle rejection strobes for the error flags
module wdata_ch_fifo
  import wdata_mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int AFULL_TH   = DEF_AFULL_TH,
  localparam int PTR_W     = ptr_w(ADDR_W)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_req,
  input  logic                  i_rd_req,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic [PTR_W-1:0]      o_count,
  output logic                  o_ovf_hit,
  output logic                  o_udf_hit
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W-1:0]      wr_nxt, rd_nxt, cnt_nxt;
  logic                  wr_ok, rd_ok;

  // Acceptance uses the registered flags, so a write into an empty channel
  // cannot be popped in the same cycle and a pop from a full channel does
  // not make room for a same-cycle write. Flush suppresses both requests
  // without counting as a rejection.
  always_comb begin
    wr_ok     = i_wr_req && !i_flush && !o_full;
    rd_ok     = i_rd_req && !i_flush && !o_empty;
    o_ovf_hit = i_wr_req && !i_flush && o_full;
    o_udf_hit = i_rd_req && !i_flush && o_empty;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    if (i_flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (wr_ok) wr_nxt = wr_ptr + PTR_W'(1);
      if (rd_ok) rd_nxt = rd_ptr + PTR_W'(1);
    end
    cnt_nxt = wr_nxt - rd_nxt;
  end

  // Status is computed from the next-state pointers so it is valid on the
  // same edge the pointers move.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
      o_afull <= 1'b0;
      o_count <= '0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      o_empty <= (wr_nxt == rd_nxt);
      o_full  <= (wr_nxt == {~rd_nxt[ADDR_W], rd_nxt[ADDR_W-1:0]});
      o_count <= cnt_nxt;
      o_afull <= (cnt_nxt >= PTR_W'(AFULL_TH));
    end
  end

  // Storage is intentionally not reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= i_data;
  end

  assign o_head = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/wdata_mc_fifo.sv
// rtl/wdata_mc_fifo.sv - multi-channel write-data FIFO, one channel per bank group
// Purpose: decodes channel selects into per-channel FIFOs, muxes the FWFT
// head of the selected read channel and keeps sticky overflow/underflow flags.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   bus             wdata_mc_fifo_if slave: requests in, data/status out
module wdata_mc_fifo
  import wdata_mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int AFULL_TH   = DEF_AFULL_TH
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  wdata_mc_fifo_if.slave bus
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = ptr_w(ADDR_W);

  logic [DATA_WIDTH-1:0]   head [NUM_CH];
  logic [NUM_CH-1:0]       full_v, empty_v, afull_v;
  logic [NUM_CH-1:0]       ovf_hit, udf_hit;
  logic [NUM_CH*PTR_W-1:0] count_v;
  logic                    err_ovf, err_udf;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic wr_req, rd_req;

    assign wr_req = bus.i_wr_en && (bus.i_wr_ch == CH_W'(k));
    assign rd_req = bus.i_rd_en && (bus.i_rd_ch == CH_W'(k));

    wdata_ch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (ADDR_W),
      .AFULL_TH   (AFULL_TH)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_req  (wr_req),
      .i_rd_req  (rd_req),
      .i_flush   (bus.i_flush[k]),
      .i_data    (bus.i_data),
      .o_head    (head[k]),
      .o_full    (full_v[k]),
      .o_empty   (empty_v[k]),
      .o_afull   (afull_v[k]),
      .o_count   (count_v[k*PTR_W +: PTR_W]),
      .o_ovf_hit (ovf_hit[k]),
      .o_udf_hit (udf_hit[k])
    );
  end

  // A rejection in the same cycle as a clear keeps the flag set so the
  // event is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (|ovf_hit)           err_ovf <= 1'b1;
      else if (bus.i_err_clr) err_ovf <= 1'b0;
      if (|udf_hit)           err_udf <= 1'b1;
      else if (bus.i_err_clr) err_udf <= 1'b0;
    end
  end

  assign bus.o_data    = head[bus.i_rd_ch];
  assign bus.o_full    = full_v;
  assign bus.o_empty   = empty_v;
  assign bus.o_afull   = afull_v;
  assign bus.o_count   = count_v;
  assign bus.o_err_ovf = err_ovf;
  assign bus.o_err_udf = err_udf;

endmodule

// File: tb/tb_wdata_mc_fifo.sv
// tb/tb_wdata_mc_fifo.sv - self-checking bench for wdata_mc_fifo against a queue model
module tb_wdata_mc_fifo;

  localparam int DW    = 1024;
  localparam int AW    = 4;
  localparam int NCH   = 4;
  localparam int ATH   = 12;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int SW    = 3*NCH + NCH*CW + 2;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  logic [DW-1:0] q [NCH][$];
  logic          exp_ovf, exp_udf;

  wdata_mc_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .NUM_CH(NCH)) bus ();

  wdata_mc_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_W     (AW),
    .NUM_CH     (NCH),
    .AFULL_TH   (ATH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [SW-1:0] exp_status();
    logic [NCH-1:0]    f, e, a;
    logic [NCH*CW-1:0] c;
    for (int k = 0; k < NCH; k++) begin
      f[k] = (q[k].size() == DEPTH);
      e[k] = (q[k].size() == 0);
      a[k] = (q[k].size() >= ATH);
      c[k*CW +: CW] = CW'(q[k].size());
    end
    return {f, e, a, c, exp_ovf, exp_udf};
  endfunction

  function automatic logic [SW-1:0] obs_status();
    return {bus.o_full, bus.o_empty, bus.o_afull, bus.o_count, bus.o_err_ovf, bus.o_err_udf};
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NCH; k++) q[k].delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endfunction

  // Entered at posedge+1; applies one cycle of requests, captures o_data
  // before the edge, and advances the model after it.
  task automatic drive_cycle(input logic wr_en, input int wr_ch, input logic [DW-1:0] d,
                             input logic rd_en, input int rd_ch, input logic [NCH-1:0] fl,
                             input logic clr, output logic racc,
                             output logic [DW-1:0] rd_obs, output logic [DW-1:0] rd_exp);
    logic wacc, ovf, udf;
    bus.i_wr_en   = wr_en;
    bus.i_wr_ch   = 2'(wr_ch);
    bus.i_data    = d;
    bus.i_rd_en   = rd_en;
    bus.i_rd_ch   = 2'(rd_ch);
    bus.i_flush   = fl;
    bus.i_err_clr = clr;
    #1;
    rd_obs = bus.o_data;
    wacc   = wr_en && !fl[wr_ch] && (q[wr_ch].size() < DEPTH);
    ovf    = wr_en && !fl[wr_ch] && (q[wr_ch].size() == DEPTH);
    racc   = rd_en && !fl[rd_ch] && (q[rd_ch].size() > 0);
    udf    = rd_en && !fl[rd_ch] && (q[rd_ch].size() == 0);
    rd_exp = racc ? q[rd_ch][0] : '0;
    @(posedge clk);
    #1;
    if (racc) void'(q[rd_ch].pop_front());
    if (wacc) q[wr_ch].push_back(d);
    for (int k = 0; k < NCH; k++) if (fl[k]) q[k].delete();
    exp_ovf = ovf ? 1'b1 : (clr ? 1'b0 : exp_ovf);
    exp_udf = udf ? 1'b1 : (clr ? 1'b0 : exp_udf);
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_flush   = '0;
    bus.i_err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_ch   = '0;
    bus.i_data    = '0;
    bus.i_rd_en   = 1'b0;
    bus.i_rd_ch   = '0;
    bus.i_flush   = '0;
    bus.i_err_clr = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (obs_status() !== {{NCH{1'b0}}, {NCH{1'b1}}, {NCH{1'b0}}, {(NCH*CW){1'b0}}, 2'b00})
      $display("FAIL reset_state: got %h want empty-only", obs_status());
    else pass_cnt++;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain();
    logic racc;
    logic [DW-1:0] obs, exp;
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b1, 2, DW'(i), 1'b0, 0, '0, 1'b0, racc, obs, exp);
      total_cnt++;
      if (bus.o_afull[2] !== (i >= 12) || bus.o_full[2] !== (i == 16))
        $display("FAIL fill_flags beat %0d: afull=%b full=%b", i, bus.o_afull[2], bus.o_full[2]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_status() !== exp_status()) $display("FAIL fill_status: got %h want %h", obs_status(), exp_status());
    else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b0, 0, '0, 1'b1, 2, '0, 1'b0, racc, obs, exp);
      total_cnt++;
      if (!racc || obs !== DW'(i)) $display("FAIL drain_data %0d: got %h want %0d", i, obs[31:0], i);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_status() !== exp_status() || bus.o_empty !== 4'hF)
      $display("FAIL drain_status: got %h want %h", obs_status(), exp_status());
    else pass_cnt++;
  endtask

  task automatic test_interleave();
    logic racc;
    logic [DW-1:0] obs, exp;
    int n0, n3, wch, rch;
    logic we;
    n0 = 0;
    n3 = 0;
    for (int c = 0; c < 48; c++) begin
      wch = (c % 2 == 0) ? 0 : 3;
      rch = (c % 2 == 0) ? 3 : 0;
      we  = ($urandom_range(0, 3) != 0) && (q[wch].size() < DEPTH);
      drive_cycle(we, wch, (wch == 0) ? DW'(32'hA0 + n0) : DW'(32'hB0 + n3),
                  $urandom_range(0, 2) == 0, rch, '0, 1'b0, racc, obs, exp);
      if (we && wch == 0) n0++;
      if (we && wch == 3) n3++;
      if (racc) begin
        total_cnt++;
        if (obs !== exp) $display("FAIL interleave_data ch%0d: got %h want %h", rch, obs[31:0], exp[31:0]);
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_status() !== exp_status()) $display("FAIL interleave_status: got %h want %h", obs_status(), exp_status());
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    logic racc;
    logic [DW-1:0] obs, exp;
    while (q[1].size() > 0) drive_cycle(1'b0, 0, '0, 1'b1, 1, '0, 1'b0, racc, obs, exp);
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1, rand_beat(), 1'b0, 0, '0, 1'b0, racc, obs, exp);
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b1, 1, rand_beat(), 1'b1, 1, '0, 1'b0, racc, obs, exp);
      total_cnt++;
      if (!racc || obs !== exp) $display("FAIL wrap_data cycle %0d: got %h want %h", c, obs[63:0], exp[63:0]);
      else pass_cnt++;
      total_cnt++;
      if (bus.o_count[1*CW +: CW] !== CW'(8)) $display("FAIL wrap_count: got %0d want 8", bus.o_count[1*CW +: CW]);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors();
    logic racc;
    logic [DW-1:0] obs, exp;
    while (q[0].size() < DEPTH) drive_cycle(1'b1, 0, rand_beat(), 1'b0, 0, '0, 1'b0, racc, obs, exp);
    while (q[1].size() > 0) drive_cycle(1'b0, 0, '0, 1'b1, 1, '0, 1'b0, racc, obs, exp);
    drive_cycle(1'b1, 0, rand_beat(), 1'b0, 0, '0, 1'b0, racc, obs, exp);
    total_cnt++;
    if (bus.o_err_ovf !== 1'b1 || bus.o_count[0 +: CW] !== CW'(16))
      $display("FAIL ovf_set: ovf=%b count=%0d want 1/16", bus.o_err_ovf, bus.o_count[0 +: CW]);
    else pass_cnt++;
    drive_cycle(1'b0, 0, '0, 1'b1, 1, '0, 1'b0, racc, obs, exp);
    total_cnt++;
    if (bus.o_err_udf !== 1'b1) $display("FAIL udf_set: got %b want 1", bus.o_err_udf);
    else pass_cnt++;
    drive_cycle(1'b1, 0, rand_beat(), 1'b0, 0, '0, 1'b1, racc, obs, exp);
    total_cnt++;
    if (bus.o_err_ovf !== 1'b1 || bus.o_err_udf !== 1'b0)
      $display("FAIL clr_vs_set: ovf=%b udf=%b want 1/0", bus.o_err_ovf, bus.o_err_udf);
    else pass_cnt++;
    drive_cycle(1'b0, 0, '0, 1'b0, 0, '0, 1'b1, racc, obs, exp);
    total_cnt++;
    if (bus.o_err_ovf !== 1'b0 || obs_status() !== exp_status())
      $display("FAIL clr_alone: got %h want %h", obs_status(), exp_status());
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic racc;
    logic [DW-1:0] obs, exp;
    while (q[3].size() > 5) drive_cycle(1'b0, 0, '0, 1'b1, 3, '0, 1'b0, racc, obs, exp);
    while (q[3].size() < 5) drive_cycle(1'b1, 3, rand_beat(), 1'b0, 0, '0, 1'b0, racc, obs, exp);
    drive_cycle(1'b1, 3, rand_beat(), 1'b1, 0, 4'b1000, 1'b0, racc, obs, exp);
    total_cnt++;
    if (bus.o_count[3*CW +: CW] !== '0 || bus.o_empty[3] !== 1'b1 || bus.o_err_ovf !== 1'b0 || bus.o_err_udf !== 1'b0)
      $display("FAIL flush_ch3: count=%0d empty=%b ovf=%b udf=%b want 0/1/0/0",
               bus.o_count[3*CW +: CW], bus.o_empty[3], bus.o_err_ovf, bus.o_err_udf);
    else pass_cnt++;
    total_cnt++;
    if (obs_status() !== exp_status()) $display("FAIL flush_status: got %h want %h", obs_status(), exp_status());
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic racc;
    logic [DW-1:0] obs, exp;
    logic [NCH-1:0] fl;
    for (int c = 0; c < 400; c++) begin
      fl = ($urandom_range(0, 19) == 0) ? NCH'(1 << $urandom_range(0, NCH-1)) : '0;
      drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, NCH-1), rand_beat(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, NCH-1), fl,
                  $urandom_range(0, 7) == 0, racc, obs, exp);
      if (racc) begin
        total_cnt++;
        if (obs !== exp) $display("FAIL random_data cycle %0d: got %h want %h", c, obs[63:0], exp[63:0]);
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_status() !== exp_status()) $display("FAIL random_status cycle %0d: got %h want %h", c, obs_status(), exp_status());
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic racc;
    logic [DW-1:0] obs, exp, beat;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1, rand_beat(), 1'b0, 0, '0, 1'b0, racc, obs, exp);
    drive_cycle(1'b1, 0, rand_beat(), 1'b1, 2, '0, 1'b0, racc, obs, exp);
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    total_cnt++;
    if (obs_status() !== exp_status()) $display("FAIL async_reset_now: got %h want %h", obs_status(), exp_status());
    else pass_cnt++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat = rand_beat();
    drive_cycle(1'b1, 1, beat, 1'b0, 0, '0, 1'b0, racc, obs, exp);
    drive_cycle(1'b0, 0, '0, 1'b1, 1, '0, 1'b0, racc, obs, exp);
    total_cnt++;
    if (!racc || obs !== beat) $display("FAIL post_reset_data: got %h want %h", obs[63:0], beat[63:0]);
    else pass_cnt++;
    total_cnt++;
    if (obs_status() !== exp_status()) $display("FAIL post_reset_status: got %h want %h", obs_status(), exp_status());
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_fill_drain();
    test_interleave();
    test_wrap();
    test_errors();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
